// File: rtl/arc4_sched.sv
// ARC4 sequencing controller: runs init, KSA and PRGA in order, hands the
// single-port S memory to whichever engine is active, and bounds each phase.
module arc4_sched #(
    parameter int TIMEOUT_W = 16,
    parameter int KEY_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic             done,
    output logic             err,
    output logic [1:0]       phase,
    output logic             init_en,
    input  logic             init_rdy,
    output logic             ksa_en,
    input  logic             ksa_rdy,
    output logic             prga_en,
    input  logic             prga_rdy,
    output logic [KEY_W-1:0] eng_key,
    input  logic [7:0]       init_s_addr,
    input  logic [7:0]       init_s_wrdata,
    input  logic             init_s_wren,
    input  logic [7:0]       ksa_s_addr,
    input  logic [7:0]       ksa_s_wrdata,
    input  logic             ksa_s_wren,
    input  logic [7:0]       prga_s_addr,
    input  logic [7:0]       prga_s_wrdata,
    input  logic             prga_s_wren,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren
);

    // Encoding keeps START/ARM/WAIT of consecutive phases adjacent so +1 steps through them.
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ERR        = 4'd1;
    localparam logic [3:0] S_INIT_START = 4'd2;
    localparam logic [3:0] S_INIT_ARM   = 4'd3;
    localparam logic [3:0] S_INIT_WAIT  = 4'd4;
    localparam logic [3:0] S_KSA_START  = 4'd5;
    localparam logic [3:0] S_KSA_ARM    = 4'd6;
    localparam logic [3:0] S_KSA_WAIT   = 4'd7;
    localparam logic [3:0] S_PRGA_START = 4'd8;
    localparam logic [3:0] S_PRGA_ARM   = 4'd9;
    localparam logic [3:0] S_PRGA_WAIT  = 4'd10;

    // Tripping one short of all-ones means ERR is occupied as the count reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] CNT_TRIP = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [3:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic                 cur_rdy, st_start, st_wait, timeout;

    always_comb begin
        unique case (state_q)
            S_INIT_START, S_INIT_ARM, S_INIT_WAIT: phase = 2'd1;
            S_KSA_START, S_KSA_ARM, S_KSA_WAIT:    phase = 2'd2;
            S_PRGA_START, S_PRGA_ARM, S_PRGA_WAIT: phase = 2'd3;
            default:                               phase = 2'd0;
        endcase
    end

    always_comb begin
        unique case (phase)
            2'd1:    cur_rdy = init_rdy;
            2'd2:    cur_rdy = ksa_rdy;
            2'd3:    cur_rdy = prga_rdy;
            default: cur_rdy = 1'b0;
        endcase
    end

    assign st_start = (state_q == S_INIT_START) || (state_q == S_KSA_START) ||
                      (state_q == S_PRGA_START);
    assign st_wait  = (state_q == S_INIT_WAIT) || (state_q == S_KSA_WAIT) ||
                      (state_q == S_PRGA_WAIT);
    assign timeout  = (cnt_q >= CNT_TRIP);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        done_d  = 1'b0;
        err_d   = err_q;
        key_d   = key_q;
        if (state_q == S_IDLE || state_q == S_ERR) begin
            if (en) begin
                state_d = S_INIT_START;
                key_d   = key;
                err_d   = 1'b0;
            end
        end else if (phase == 2'd0) begin
            state_d = S_IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (st_start) begin
                if (cur_rdy)      state_d = state_q + 4'd1;
                else if (timeout) state_d = S_ERR;
            end else if (st_wait && cur_rdy) begin
                state_d = (state_q == S_PRGA_WAIT) ? S_IDLE : state_q + 4'd1;
                done_d  = (state_q == S_PRGA_WAIT);
            end else if (timeout) begin
                state_d = S_ERR;
            end else if (!st_wait) begin
                state_d = state_q + 4'd1;
            end
            if (state_d == S_ERR) err_d = 1'b1;
            if (state_d != state_q && (state_d == S_KSA_START || state_d == S_PRGA_START))
                cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            key_q   <= key_d;
        end
    end

    // Enables are gated by rst so a reset cycle never launches an engine.
    assign init_en = (state_q == S_INIT_START) & init_rdy & ~rst;
    assign ksa_en  = (state_q == S_KSA_START)  & ksa_rdy  & ~rst;
    assign prga_en = (state_q == S_PRGA_START) & prga_rdy & ~rst;

    assign rdy     = (state_q == S_IDLE) || (state_q == S_ERR);
    assign done    = done_q;
    assign err     = err_q;
    assign eng_key = key_q;

    always_comb begin
        unique case (phase)
            2'd1:    begin s_addr = init_s_addr; s_wrdata = init_s_wrdata; s_wren = init_s_wren; end
            2'd2:    begin s_addr = ksa_s_addr;  s_wrdata = ksa_s_wrdata;  s_wren = ksa_s_wren;  end
            2'd3:    begin s_addr = prga_s_addr; s_wrdata = prga_s_wrdata; s_wren = prga_s_wren; end
            default: begin s_addr = 8'h00;       s_wrdata = 8'h00;         s_wren = 1'b0;        end
        endcase
    end

endmodule

// File: tb/tb_arc4_sched.sv
// Scoreboarded bench for arc4_sched: mock engines, event predictions from the
// timing rules, and a separate monitor that pops and compares each DUT event.
module tb_arc4_sched;

    typedef struct {
        logic [3:0] ev;   // {done, prga_en, ksa_en, init_en}
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    // main instance signals
    logic        rst, en, rdy, done, err;
    logic [23:0] key, eng_key;
    logic [1:0]  phase;
    logic        init_en, ksa_en, prga_en, init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;

    // watchdog instance signals
    logic        w_rst, w_en, w_rdy, w_done, w_err;
    logic [23:0] w_key, w_eng_key;
    logic [1:0]  w_phase;
    logic        w_init_en, w_ksa_en, w_prga_en, w_init_rdy, w_ksa_rdy, w_prga_rdy;
    logic [7:0]  w_s_addr, w_s_wrdata;
    logic        w_s_wren;

    // shared engine memory requests
    logic [7:0] init_s_addr, init_s_wrdata, ksa_s_addr, ksa_s_wrdata, prga_s_addr, prga_s_wrdata;
    logic       init_s_wren, ksa_s_wren, prga_s_wren;

    arc4_sched dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .done(done), .err(err),
        .phase(phase), .init_en(init_en), .init_rdy(init_rdy), .ksa_en(ksa_en),
        .ksa_rdy(ksa_rdy), .prga_en(prga_en), .prga_rdy(prga_rdy), .eng_key(eng_key),
        .init_s_addr(init_s_addr), .init_s_wrdata(init_s_wrdata), .init_s_wren(init_s_wren),
        .ksa_s_addr(ksa_s_addr), .ksa_s_wrdata(ksa_s_wrdata), .ksa_s_wren(ksa_s_wren),
        .prga_s_addr(prga_s_addr), .prga_s_wrdata(prga_s_wrdata), .prga_s_wren(prga_s_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    arc4_sched #(.TIMEOUT_W(4)) dut_wd (
        .clk(clk), .rst(w_rst), .en(w_en), .rdy(w_rdy), .key(w_key), .done(w_done), .err(w_err),
        .phase(w_phase), .init_en(w_init_en), .init_rdy(w_init_rdy), .ksa_en(w_ksa_en),
        .ksa_rdy(w_ksa_rdy), .prga_en(w_prga_en), .prga_rdy(w_prga_rdy), .eng_key(w_eng_key),
        .init_s_addr(init_s_addr), .init_s_wrdata(init_s_wrdata), .init_s_wren(init_s_wren),
        .ksa_s_addr(ksa_s_addr), .ksa_s_wrdata(ksa_s_wrdata), .ksa_s_wren(ksa_s_wren),
        .prga_s_addr(prga_s_addr), .prga_s_wrdata(prga_s_wrdata), .prga_s_wren(prga_s_wren),
        .s_addr(w_s_addr), .s_wrdata(w_s_wrdata), .s_wren(w_s_wren)
    );

    // Mock engines: rdy drops the cycle after en and returns after 'busy' cycles.
    int         busy [3];
    int         m0_cnt [3];
    int         m1_cnt [3];
    logic [2:0] m0_rdy = 3'b111;
    logic [2:0] m1_rdy = 3'b111;
    wire  [2:0] en0 = {prga_en, ksa_en, init_en};
    wire  [2:0] en1 = {w_prga_en, w_ksa_en, w_init_en};
    int         blk_lo = 1, blk_hi = 0;

    always @(posedge clk) begin
        for (int e = 0; e < 3; e++) begin
            if (en0[e]) begin
                m0_cnt[e] <= busy[e];
                m0_rdy[e] <= 1'b0;
            end else if (!m0_rdy[e]) begin
                if (m0_cnt[e] <= 1) m0_rdy[e] <= 1'b1;
                m0_cnt[e] <= m0_cnt[e] - 1;
            end
            if (en1[e]) begin
                m1_cnt[e] <= 3;
                m1_rdy[e] <= 1'b0;
            end else if (!m1_rdy[e]) begin
                if (m1_cnt[e] <= 1) m1_rdy[e] <= 1'b1;
                m1_cnt[e] <= m1_cnt[e] - 1;
            end
        end
    end

    assign init_rdy   = m0_rdy[0];
    assign ksa_rdy    = m0_rdy[1] & ~((cyc >= blk_lo) && (cyc <= blk_hi));
    assign prga_rdy   = m0_rdy[2];
    assign w_init_rdy = m1_rdy[0];
    assign w_ksa_rdy  = m1_rdy[1];
    assign w_prga_rdy = 1'b0;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [23:0] exp_key = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic sb_pop(input int inst, input logic [3:0] ev);
        exp_t x;
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL sb%0d_unexpected: got event %b expected none (cycle %0d)", inst, ev, cyc);
        end else begin
            x = (inst == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("sb%0d_event", inst), {28'd0, ev}, {28'd0, x.ev});
            chk($sformatf("sb%0d_cycle", inst), cyc, x.cyc);
        end
    endtask

    // Monitor: compares every enable/done pulse against the predicted queue.
    always @(negedge clk) begin : mon
        logic [3:0]  ev0, ev1;
        logic [16:0] arb;
        if (mon_on) begin
            ev0 = {done, prga_en, ksa_en, init_en};
            ev1 = {w_done, w_prga_en, w_ksa_en, w_init_en};
            if (ev0 != 4'd0) sb_pop(0, ev0);
            if (ev1 != 4'd0) sb_pop(1, ev1);
            if (init_en) chk("phase_at_init_en", phase, 1);
            if (ksa_en)  chk("phase_at_ksa_en", phase, 2);
            if (prga_en) chk("phase_at_prga_en", phase, 3);
            if (done)    chk("rdy_with_done", rdy, 1);
            case (phase)
                2'd1:    arb = {init_s_wren, init_s_wrdata, init_s_addr};
                2'd2:    arb = {ksa_s_wren, ksa_s_wrdata, ksa_s_addr};
                2'd3:    arb = {prga_s_wren, prga_s_wrdata, prga_s_addr};
                default: arb = '0;
            endcase
            chk("arb_mux", {15'd0, s_wren, s_wrdata, s_addr}, {15'd0, arb});
            chk("eng_key", {8'd0, eng_key}, {8'd0, exp_key});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        init_s_wrdata = 8'($urandom);
        ksa_s_wrdata  = 8'($urandom);
        prga_s_wrdata = 8'($urandom);
        init_s_wren   = ($urandom_range(0, 3) != 0);
        ksa_s_wren    = ($urandom_range(0, 3) != 0);
        prga_s_wren   = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run(input logic [23:0] k, input int bi, input int bk, input int bp,
                       input int kb, input bit poke, input bit rst_mid);
        int a, e1, k1, e2, k2, e3, k3, dn;
        busy[0] = bi; busy[1] = bk; busy[2] = bp;
        a  = cyc;
        e1 = a + 1;
        k1 = e1 + bi + 1;
        e2 = k1 + 1 + kb;
        k2 = e2 + bk + 1;
        e3 = k2 + 1;
        k3 = e3 + bp + 1;
        dn = k3 + 1;
        blk_lo = k1 + 1;
        blk_hi = k1 + kb;
        q0.push_back('{4'b0001, e1});
        q0.push_back('{4'b0010, e2});
        if (!rst_mid) begin
            q0.push_back('{4'b0100, e3});
            q0.push_back('{4'b1000, dn});
        end
        en = 1'b1; key = k;
        tick();
        en = 1'b0; key = 24'($urandom);
        exp_key = k;
        chk("rdy_after_accept", rdy, 0);
        chk("phase_init_start", phase, 1);
        while (cyc < (rst_mid ? e2 + 3 : dn + 1)) begin
            if (kb > 0 && cyc == k1 + 1) chk("ksa_start_hold_phase", phase, 2);
            if (poke && cyc == e2 + 2) begin en = 1'b1; key = 24'($urandom); end
            if (poke && cyc == e2 + 5) en = 1'b0;
            tick();
        end
        if (rst_mid) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            exp_key = '0;
            chk("rst_rdy", rdy, 1);
            chk("rst_phase", phase, 0);
            chk("rst_err_done", {err, done}, 0);
            chk("rst_enables", {init_en, ksa_en, prga_en}, 0);
            chk("rst_mem", {s_wren, s_addr, s_wrdata}, 0);
            repeat (bk + 5) tick();
        end else begin
            chk("idle_rdy", rdy, 1);
            chk("idle_phase", phase, 0);
            chk("done_one_cycle", done, 0);
            chk("no_err", err, 0);
        end
        chk("sb0_drained", q0.size(), 0);
        blk_lo = 1; blk_hi = 0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; w_rst = 1'b1;
        en = 1'b0; w_en = 1'b0;
        key = '0; w_key = '0;
        init_s_addr = 8'h11; ksa_s_addr = 8'h22; prga_s_addr = 8'h33;
        init_s_wren = 1'b1; ksa_s_wren = 1'b1; prga_s_wren = 1'b1;
        init_s_wrdata = 8'h00; ksa_s_wrdata = 8'h00; prga_s_wrdata = 8'h00;
        busy[0] = 1; busy[1] = 1; busy[2] = 1;
        repeat (3) tick();
        rst = 1'b0; w_rst = 1'b0;
        chk("reset_rdy", rdy, 1);
        chk("reset_phase", phase, 0);
        chk("reset_done_err", {done, err}, 0);
        chk("reset_eng_key", eng_key, 0);
        chk("reset_enables", {init_en, ksa_en, prga_en}, 0);
        chk("reset_mem", {s_wren, s_addr, s_wrdata}, 0);
        mon_on = 1'b1;

        run(24'h000018, 256, 768, 1000, 0, 1'b0, 1'b0);
        run(24'($urandom), 20, 20, 20, 5, 1'b0, 1'b0);
        run(24'($urandom), 12, 30, 9, 0, 1'b1, 1'b0);
        run(24'($urandom), 10, 40, 10, 0, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++)
            run(24'($urandom), $urandom_range(1, 30), $urandom_range(8, 30),
                $urandom_range(1, 30), $urandom_range(0, 6), 1'($urandom), 1'b0);

        // Watchdog: prga_rdy stuck low, TIMEOUT_W=4 -> ERR 15 cycles after PRGA_START.
        begin
            int a;
            a = cyc;
            w_en = 1'b1; w_key = 24'($urandom);
            q1.push_back('{4'b0001, a + 1});
            q1.push_back('{4'b0010, a + 6});
            tick();
            w_en = 1'b0;
            while (cyc < a + 25) tick();
            chk("wd_before_phase", w_phase, 3);
            chk("wd_before_err", w_err, 0);
            tick();
            chk("wd_err", w_err, 1);
            chk("wd_rdy", w_rdy, 1);
            chk("wd_phase", w_phase, 0);
            chk("wd_no_done", w_done, 0);
            tick();
            chk("wd_err_sticky", w_err, 1);
            w_en = 1'b1;
            q1.push_back('{4'b0001, a + 28});
            q1.push_back('{4'b0010, a + 33});
            tick();
            w_en = 1'b0;
            chk("wd_err_cleared", w_err, 0);
            chk("wd_restart_phase", w_phase, 1);
            while (cyc < a + 40) tick();
            chk("wd_sb_drained", q1.size(), 0);
            w_rst = 1'b1;
            tick();
            w_rst = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
